// File: rtl/ctrl_pkg.sv
// Shared definitions for the systolic array controller: opcode values,
// array mode encoding, instruction field positions and the decode struct.
package ctrl_pkg;

    typedef enum logic [4:0] {
        OP_NOP       = 5'd0,
        OP_MAC       = 5'd1,
        OP_SEND_WT   = 5'd2,
        OP_STORE_OUT = 5'd3,
        OP_RECV_INP  = 5'd4,
        OP_RECV_WT   = 5'd5,
        OP_TX_OUT    = 5'd6,
        OP_RST_ACC   = 5'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD_WT = 2'b01,
        ST_COMPUTE = 2'b10,
        ST_DRAIN   = 2'b11
    } array_state_e;

    // Instruction word layout
    localparam int INSTR_W  = 64;
    localparam int OPC_LSB  = 0;
    localparam int OPC_MSB  = 4;
    localparam int ADDR_LSB = 5;
    localparam int ADDR_MSB = 20;
    localparam int DATA_LSB = 21;
    localparam int DATA_MSB = 52;
    localparam int ADDR_FW  = ADDR_MSB - ADDR_LSB + 1;

    // One-hot opcode decode; anything outside 0..7 lands on nop
    typedef struct packed {
        logic nop;
        logic mac;
        logic send_wt;
        logic store_out;
        logic recv_inp;
        logic recv_wt;
        logic tx_out;
        logic rst_acc;
    } dec_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational opcode to one-hot decode.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [4:0] i_opcode,
    output dec_t       o_dec
);

    // Exactly one field of o_dec is set for every opcode value
    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_MAC:       o_dec.mac       = 1'b1;
            OP_SEND_WT:   o_dec.send_wt   = 1'b1;
            OP_STORE_OUT: o_dec.store_out = 1'b1;
            OP_RECV_INP:  o_dec.recv_inp  = 1'b1;
            OP_RECV_WT:   o_dec.recv_wt   = 1'b1;
            OP_TX_OUT:    o_dec.tx_out    = 1'b1;
            OP_RST_ACC:   o_dec.rst_acc   = 1'b1;
            default:      o_dec.nop       = 1'b1;
        endcase
    end

endmodule

// File: rtl/systolic_controller.sv
// Instruction-driven controller for a systolic array: registers buffer
// write address/data, output-buffer commands, accumulator clear and the
// array mode, all with one cycle of latency.
// Optional build macro CTRL_ADDR_CHECK_EN: out-of-range buffer addresses
// drop the instruction instead of truncating the address.
module systolic_controller
    import ctrl_pkg::*;
#(
    parameter int BUF_ADDR_W = 14,
    parameter int DATA_W     = 32,
    parameter int OUT_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INSTR_W-1:0]    instruction,
    output logic [BUF_ADDR_W-1:0] inp_buf_addr,
    output logic [DATA_W-1:0]     inp_buf_data,
    output logic [BUF_ADDR_W-1:0] wt_buf_addr,
    output logic [DATA_W-1:0]     wt_buf_data,
    output logic                  inp_buf_wr_en,
    output logic                  wt_buf_wr_en,
    output logic [OUT_ADDR_W-1:0] acc_to_op_buf_addr,
    output logic                  acc_result_to_op_buf,
    output logic [OUT_ADDR_W-1:0] out_buf_addr,
    output logic                  op_buffer_instr_for_sending_data,
    output logic                  instr_for_accum_to_reset,
    output logic [1:0]            state_signal,
    output logic                  i_mode
);

    logic [4:0]         w_opcode;
    logic [ADDR_FW-1:0] w_addr;
    logic [DATA_W-1:0]  w_data;
    dec_t               w_dec;
    logic               w_buf_addr_ok;
    logic               w_out_addr_ok;
    logic               w_unused;

    assign w_opcode = instruction[OPC_MSB:OPC_LSB];
    assign w_addr   = instruction[ADDR_MSB:ADDR_LSB];
    assign w_data   = instruction[DATA_LSB +: DATA_W];
    assign w_unused = ^{instruction[INSTR_W-1:DATA_MSB+1], w_addr};

`ifdef CTRL_ADDR_CHECK_EN
    assign w_buf_addr_ok = ((w_addr >> BUF_ADDR_W) == '0);
    assign w_out_addr_ok = ((w_addr >> OUT_ADDR_W) == '0);
`else
    assign w_buf_addr_ok = 1'b1;
    assign w_out_addr_ok = 1'b1;
`endif

    ctrl_decoder u_dec (
        .i_opcode (w_opcode),
        .o_dec    (w_dec)
    );

    // Strobes pulse per sampled instruction; addr/data hold until the next
    // instruction of the same kind; mode follows the latest opcode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inp_buf_addr                     <= '0;
            inp_buf_data                     <= '0;
            wt_buf_addr                      <= '0;
            wt_buf_data                      <= '0;
            inp_buf_wr_en                    <= 1'b0;
            wt_buf_wr_en                     <= 1'b0;
            acc_to_op_buf_addr               <= '0;
            acc_result_to_op_buf             <= 1'b0;
            out_buf_addr                     <= '0;
            op_buffer_instr_for_sending_data <= 1'b0;
            instr_for_accum_to_reset         <= 1'b0;
            state_signal                     <= ST_IDLE;
            i_mode                           <= 1'b0;
        end else begin
            inp_buf_wr_en                    <= w_dec.recv_inp  & w_buf_addr_ok;
            wt_buf_wr_en                     <= w_dec.recv_wt   & w_buf_addr_ok;
            acc_result_to_op_buf             <= w_dec.store_out & w_out_addr_ok;
            op_buffer_instr_for_sending_data <= w_dec.tx_out    & w_out_addr_ok;
            instr_for_accum_to_reset         <= w_dec.rst_acc;

            if (w_dec.recv_inp && w_buf_addr_ok) begin
                inp_buf_addr <= w_addr[BUF_ADDR_W-1:0];
                inp_buf_data <= w_data;
            end
            if (w_dec.recv_wt && w_buf_addr_ok) begin
                wt_buf_addr <= w_addr[BUF_ADDR_W-1:0];
                wt_buf_data <= w_data;
            end
            if (w_dec.store_out && w_out_addr_ok)
                acc_to_op_buf_addr <= w_addr[OUT_ADDR_W-1:0];
            if (w_dec.tx_out && w_out_addr_ok)
                out_buf_addr <= w_addr[OUT_ADDR_W-1:0];

            if (w_dec.mac)
                state_signal <= ST_COMPUTE;
            else if (w_dec.send_wt)
                state_signal <= ST_LOAD_WT;
            else if (w_dec.store_out || w_dec.tx_out)
                state_signal <= ST_DRAIN;
            else
                state_signal <= ST_IDLE;

            if (w_dec.mac)
                i_mode <= 1'b1;
            else if (w_dec.send_wt)
                i_mode <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_controller.sv
// Directed self-checking bench for systolic_controller.
module tb_systolic_controller;

    logic        clk;
    logic        rst_n;
    logic [63:0] instruction;
    logic [13:0] inp_buf_addr, wt_buf_addr;
    logic [31:0] inp_buf_data, wt_buf_data;
    logic        inp_buf_wr_en, wt_buf_wr_en;
    logic [3:0]  acc_to_op_buf_addr, out_buf_addr;
    logic        acc_result_to_op_buf, op_buffer_instr_for_sending_data;
    logic        instr_for_accum_to_reset;
    logic [1:0]  state_signal;
    logic        i_mode;

    int errors = 0;
    int checks = 0;

    systolic_controller dut (
        .clk                              (clk),
        .rst_n                            (rst_n),
        .instruction                      (instruction),
        .inp_buf_addr                     (inp_buf_addr),
        .inp_buf_data                     (inp_buf_data),
        .wt_buf_addr                      (wt_buf_addr),
        .wt_buf_data                      (wt_buf_data),
        .inp_buf_wr_en                    (inp_buf_wr_en),
        .wt_buf_wr_en                     (wt_buf_wr_en),
        .acc_to_op_buf_addr               (acc_to_op_buf_addr),
        .acc_result_to_op_buf             (acc_result_to_op_buf),
        .out_buf_addr                     (out_buf_addr),
        .op_buffer_instr_for_sending_data (op_buffer_instr_for_sending_data),
        .instr_for_accum_to_reset         (instr_for_accum_to_reset),
        .state_signal                     (state_signal),
        .i_mode                           (i_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe vector order: {inp_wr, wt_wr, store_out, tx_out, rst_acc}
    function automatic logic [4:0] strobes();
        return {inp_buf_wr_en, wt_buf_wr_en, acc_result_to_op_buf,
                op_buffer_instr_for_sending_data, instr_for_accum_to_reset};
    endfunction

    // Drive one instruction before the edge, sample 1 time unit after it
    task automatic step(input logic [4:0] op, input logic [15:0] addr,
                        input logic [31:0] data);
        @(negedge clk);
        instruction = {11'h0, data, addr, op};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(5'd5, 16'h0007, 32'h1234_5678);
        step(5'd5, 16'h0007, 32'h1234_5678);
        checks++;
        if ({inp_buf_addr, inp_buf_data, wt_buf_addr, wt_buf_data,
             acc_to_op_buf_addr, out_buf_addr} !== '0) begin
            errors++;
            $display("FAIL reset_regs: wt_addr=%h wt_data=%h inp_addr=%h", wt_buf_addr, wt_buf_data, inp_buf_addr);
        end
        checks++;
        if (strobes() !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000", strobes());
        end
        checks++;
        if ({state_signal, i_mode} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mode: got st=%b im=%b want 00/0", state_signal, i_mode);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_input_load();
        step(5'd4, 16'h0001, 32'hDEADBEEF);
        checks++;
        if (inp_buf_addr !== 14'h0001 || inp_buf_data !== 32'hDEADBEEF || strobes() !== 5'b10000) begin
            errors++;
            $display("FAIL input_load: addr=%h data=%h stb=%b want 0001 deadbeef 10000", inp_buf_addr, inp_buf_data, strobes());
        end
        step(5'd0, 16'h0000, 32'h0);
        checks++;
        if (strobes() !== 5'b0 || inp_buf_addr !== 14'h0001 || inp_buf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL input_hold: addr=%h data=%h stb=%b", inp_buf_addr, inp_buf_data, strobes());
        end
    endtask

    task automatic test_weight_load();
        // upper ignored bits set as well
        @(negedge clk);
        instruction = {11'h7FF, 32'hCAFEBABE, 16'h0002, 5'd5};
        @(posedge clk);
        #1;
        checks++;
        if (wt_buf_addr !== 14'h0002 || wt_buf_data !== 32'hCAFEBABE || strobes() !== 5'b01000) begin
            errors++;
            $display("FAIL weight_load: addr=%h data=%h stb=%b want 0002 cafebabe 01000", wt_buf_addr, wt_buf_data, strobes());
        end
        checks++;
        if (inp_buf_addr !== 14'h0001 || inp_buf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL weight_inp_kept: addr=%h data=%h want 0001 deadbeef", inp_buf_addr, inp_buf_data);
        end
    endtask

    task automatic test_mode_seq();
        logic [4:0] ops [3]   = '{5'd2, 5'd1, 5'd0};
        logic [1:0] exp_st[3] = '{2'b01, 2'b10, 2'b00};
        logic       exp_im[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(ops[i], 16'h0, 32'h0);
            checks++;
            if (state_signal !== exp_st[i] || i_mode !== exp_im[i] || strobes() !== 5'b0) begin
                errors++;
                $display("FAIL mode_seq[%0d]: st=%b im=%b stb=%b want %b %b 00000", i, state_signal, i_mode, strobes(), exp_st[i], exp_im[i]);
            end
        end
    endtask

    task automatic test_output_path();
        step(5'd3, 16'h0003, 32'h0);
        checks++;
        if (acc_to_op_buf_addr !== 4'd3 || strobes() !== 5'b00100 || state_signal !== 2'b11) begin
            errors++;
            $display("FAIL store_out: addr=%0d stb=%b st=%b want 3 00100 11", acc_to_op_buf_addr, strobes(), state_signal);
        end
        step(5'd6, 16'h0004, 32'h0);
        checks++;
        if (out_buf_addr !== 4'd4 || acc_to_op_buf_addr !== 4'd3 || strobes() !== 5'b00010 || state_signal !== 2'b11) begin
            errors++;
            $display("FAIL tx_out: addr=%0d acc_addr=%0d stb=%b st=%b want 4 3 00010 11", out_buf_addr, acc_to_op_buf_addr, strobes(), state_signal);
        end
        step(5'd7, 16'h0000, 32'h0);
        checks++;
        if (strobes() !== 5'b00001 || state_signal !== 2'b00 || i_mode !== 1'b1) begin
            errors++;
            $display("FAIL rst_acc: stb=%b st=%b im=%b want 00001 00 1", strobes(), state_signal, i_mode);
        end
    endtask

    task automatic test_back_to_back();
        int cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(5'd5, 16'h0010 + 16'(i), 32'h100 + 32'(i));
            if (wt_buf_wr_en === 1'b1) cnt++;
        end
        step(5'd0, 16'h0, 32'h0);
        if (wt_buf_wr_en === 1'b1) cnt++;
        checks++;
        if (cnt !== 3 || wt_buf_addr !== 14'h0012 || wt_buf_data !== 32'h102) begin
            errors++;
            $display("FAIL back_to_back: strobe_cycles=%0d addr=%h data=%h want 3 0012 00000102", cnt, wt_buf_addr, wt_buf_data);
        end
    endtask

    task automatic test_high_opcode();
        step(5'd2, 16'h0, 32'h0);
        step(5'd9, 16'h0005, 32'hFFFF_FFFF);
        checks++;
        if (strobes() !== 5'b0 || state_signal !== 2'b00 || i_mode !== 1'b0 || inp_buf_addr !== 14'h0001) begin
            errors++;
            $display("FAIL high_opcode: stb=%b st=%b im=%b inp_addr=%h want 00000 00 0 0001", strobes(), state_signal, i_mode, inp_buf_addr);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        instruction = {11'h0, 32'h55, 16'h0009, 5'd4};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (strobes() !== 5'b0 || inp_buf_addr !== 14'h0 || inp_buf_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: stb=%b addr=%h data=%h want 00000 0 0", strobes(), inp_buf_addr, inp_buf_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_addr_range();
        step(5'd4, 16'h0021, 32'hA5A5_A5A5);
        step(5'd4, 16'h4000, 32'h1111_1111);
`ifdef CTRL_ADDR_CHECK_EN
        checks++;
        if (inp_buf_wr_en !== 1'b0 || inp_buf_addr !== 14'h0021 || inp_buf_data !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL addr_check_inp: wr=%b addr=%h data=%h want 0 0021 a5a5a5a5", inp_buf_wr_en, inp_buf_addr, inp_buf_data);
        end
        step(5'd3, 16'h0013, 32'h0);
        checks++;
        if (acc_result_to_op_buf !== 1'b0 || acc_to_op_buf_addr !== 4'd0) begin
            errors++;
            $display("FAIL addr_check_out: stb=%b addr=%0d want 0 0", acc_result_to_op_buf, acc_to_op_buf_addr);
        end
`else
        checks++;
        if (inp_buf_wr_en !== 1'b1 || inp_buf_addr !== 14'h0000 || inp_buf_data !== 32'h1111_1111) begin
            errors++;
            $display("FAIL addr_trunc_inp: wr=%b addr=%h data=%h want 1 0000 11111111", inp_buf_wr_en, inp_buf_addr, inp_buf_data);
        end
        step(5'd3, 16'h0013, 32'h0);
        checks++;
        if (acc_result_to_op_buf !== 1'b1 || acc_to_op_buf_addr !== 4'd3) begin
            errors++;
            $display("FAIL addr_trunc_out: stb=%b addr=%0d want 1 3", acc_result_to_op_buf, acc_to_op_buf_addr);
        end
`endif
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = '0;
        test_reset();
        test_input_load();
        test_weight_load();
        test_mode_seq();
        test_output_path();
        test_back_to_back();
        test_high_opcode();
        test_reset_mid();
        test_addr_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
